demux_1by16_tdm: RTL

Receive-side partner of the 16:1 multiplexer: a clocked 1-to-16 time-division demultiplexer. It takes the serial bit stream produced by stepping the mux select through slots 0..15, locks to a frame-start marker, and steers each bit into its slot position. It presents the completed 16-bit frame with a one-cycle valid strobe. It sits directly after a mux-based serializer, or after any link carrying its slot stream.

---
 rtl/demux_1by16_tdm.sv | 99 +++++++++
 1 files changed

// File: rtl/demux_1by16_tdm.sv
// demux_1by16_tdm: 1-to-16 time-division demultiplexer that locks to a
// frame-start marker and assembles each 16-slot serial frame into a word.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     in/sync carry a slot bit this cycle
//   in           serial slot bit
//   sync         frame-start marker, marks the current bit as slot 0
//   sel          slot index the next accepted bit is written to
//   out          assembly register, bit i = slot i of the frame in progress
//   frame        last completed frame
//   frame_valid  one-cycle strobe when frame updates
//   locked       framer is locked to the slot stream
//   sync_err     one-cycle strobe on a framing error
module demux_1by16_tdm #(
  parameter int SLOTS = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             sync,
  output logic [SEL_W-1:0] sel,
  output logic [SLOTS-1:0] out,
  output logic [SLOTS-1:0] frame,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [SLOTS-1:0] out_n;
  logic [SLOTS-1:0] frame_n;
  logic             fv_n;
  logic             err_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      sel         <= '0;
      out         <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      out         <= out_n;
      frame       <= frame_n;
      frame_valid <= fv_n;
      sync_err    <= err_n;
    end
  end

  // state is itself a register, so locked stays a registered output
  assign locked = (state == LOCKED);

  always_comb begin
    state_n = state;
    sel_n   = sel;
    out_n   = out;
    frame_n = frame;
    fv_n    = 1'b0;
    err_n   = 1'b0;
    if (in_valid) begin
      if (sync) begin
        // sync always restarts at slot 0; mid-frame it drops the partial
        if (state == LOCKED && sel != '0) begin
          err_n = 1'b1;
        end
        out_n    = '0;
        out_n[0] = in;
        sel_n    = SEL_W'(1);
        state_n  = LOCKED;
      end else if (state == LOCKED) begin
        if (sel == '0) begin
          // slot 0 arrived without its marker: framing is lost
          err_n   = 1'b1;
          state_n = HUNT;
        end else begin
          out_n[sel] = in;
          sel_n      = sel + SEL_W'(1);
          if (sel == SEL_W'(SLOTS - 1)) begin
            frame_n = {in, out[SLOTS-2:0]};
            fv_n    = 1'b1;
          end
        end
      end
    end
  end

endmodule
